demux_1_4_reg: RTL and testbench

//   Registered 1:4 demultiplexer with a valid/ready handshake on each side. It routes one
//   W-bit input word to one of four output channels, chosen by a 2-bit select.

---
 rtl/demux_1_4_reg_if.sv | 31 +++
 rtl/demux_1_4_reg.sv | 76 +++++++
 tb/tb_demux_1_4_reg.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/demux_1_4_reg_if.sv
// Bundle of the input-side and output-side handshake signals of the
// registered 1:4 demultiplexer. The master side drives words in and takes
// them out. The slave side is the demultiplexer itself.
interface demux_1_4_reg_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  // Input side: one word plus its destination channel.
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [1:0]       in_sel;

  // Output side: one handshake per channel, with data and counters packed {ch3,ch2,ch1,ch0}.
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [4*W-1:0]   out_data;
  logic [4*CNT_W-1:0] count;

  // Producer and consumer of the words.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  // The demultiplexer.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/demux_1_4_reg.sv
// Registered 1:4 demultiplexer. An input word is routed by in_sel into one
// of four single-entry holding registers, each with its own valid/ready
// handshake. Each channel also keeps a saturating count of accepted words.
// Only the selected channel can stall the input. A full channel never
// blocks traffic aimed at another channel.
module demux_1_4_reg #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  demux_1_4_reg_if.slave bus
);

  logic [3:0]       valid_q;
  logic [W-1:0]     data_q [4];
  logic [CNT_W-1:0] cnt_q  [4];

  logic             acc;
  logic [3:0]       load;
  logic [3:0]       take;

  // The selected channel can take a word if it is empty or being drained this cycle.
  // in_ready is held low while in reset.
  assign bus.in_ready = rst_n & (~valid_q[bus.in_sel] | bus.out_ready[bus.in_sel]);
  assign acc          = bus.in_valid & bus.in_ready;
  assign take         = valid_q & bus.out_ready;

  // Decode the accepted word into a one-hot load strobe for the destination channel.
  always_comb begin
    // NOTE: each always_comb output gets a default before any condition, so no path leaves it unassigned and no latch is inferred.
    load = '0;
    if (acc) begin
      load[bus.in_sel] = 1'b1;
    end
  end

  // Per-channel holding registers and counters. A load takes priority over a drain, so a channel can drain and reload in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking (<=) so every register updates from values sampled before the edge.
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < 4; i++) begin
        // NOTE: the data registers are reset as well as the valid flags, so out_data reads zero after reset.
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          data_q[i]  <= bus.in_data;
          valid_q[i] <= 1'b1;
        end else if (take[i]) begin
          valid_q[i] <= 1'b0;
        end

        if (load[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Pack the per-channel registers onto the flat output buses.
  always_comb begin
    bus.out_data = '0;
    bus.count    = '0;
    for (int i = 0; i < 4; i++) begin
      bus.out_data[i*W +: W]         = data_q[i];
      bus.count[i*CNT_W +: CNT_W]    = cnt_q[i];
    end
  end

  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_demux_1_4_reg.sv
// Self-checking bench for demux_1_4_reg. A table of directed vectors covers
// reset, routing, backpressure and drain+load. Hand-written sequences cover
// the back-to-back stream, a mid-run reset and counter saturation. The
// saturation sequence runs on a second instance built with CNT_W=2.
module tb_demux_1_4_reg;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  demux_1_4_reg_if #(.W(W), .CNT_W(8)) bus  ();
  demux_1_4_reg_if #(.W(W), .CNT_W(2)) bus2 ();

  demux_1_4_reg #(.W(W), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  demux_1_4_reg #(.W(W), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic [1:0]  sel;
    logic [3:0]  data;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [15:0] exp_od;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [$];
  int   n_checks    = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [1:0] s, input logic [3:0] d,
                     input logic [3:0] o, input logic er, input logic [3:0] eov,
                     input logic [15:0] eod, input logic [31:0] ec);
    vec_t t;
    t = '{r, v, s, d, o, er, eov, eod, ec};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] s,
                       input logic [3:0] d, input logic [3:0] o);
    rst_n         = r;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int accepts;

  initial begin
    drive(1'b0, 1'b0, 2'd0, 4'h0, 4'b0000);
    bus2.in_valid  = 1'b0;
    bus2.in_sel    = 2'd0;
    bus2.in_data   = 4'h0;
    bus2.out_ready = 4'b0000;

    //   rst vld sel data ordy   rdy  ov       od        cnt
    // Reset for two cycles, then release with no input.
    add(0, 0, 0, 4'h0, 4'b0000, 0, 4'b0000, 16'h0000, 32'h00000000);
    add(0, 0, 0, 4'h0, 4'b0000, 0, 4'b0000, 16'h0000, 32'h00000000);
    add(1, 0, 0, 4'h0, 4'b0000, 1, 4'b0000, 16'h0000, 32'h00000000);
    // Route A,B,C,D to channels 0..3 with every consumer stalled.
    add(1, 1, 0, 4'hA, 4'b0000, 1, 4'b0001, 16'h000A, 32'h00000001);
    add(1, 1, 1, 4'hB, 4'b0000, 1, 4'b0011, 16'h00BA, 32'h00000101);
    add(1, 1, 2, 4'hC, 4'b0000, 1, 4'b0111, 16'h0CBA, 32'h00010101);
    add(1, 1, 3, 4'hD, 4'b0000, 1, 4'b1111, 16'hDCBA, 32'h01010101);
    // Drain channel 1 only. in_sel=0 points at a full, stalled channel, so in_ready=0.
    add(1, 0, 0, 4'h0, 4'b0010, 0, 4'b1101, 16'hDCBA, 32'h01010101);
    // Backpressure: channel 2 full and stalled, so the word 7 is refused.
    add(1, 1, 2, 4'h7, 4'b0000, 0, 4'b1101, 16'hDCBA, 32'h01010101);
    // The empty channel 1 still accepts while channel 2 is full.
    add(1, 1, 1, 4'h6, 4'b0000, 1, 4'b1111, 16'hDC6A, 32'h01010201);
    // Drain+load channel 0 with 3, then again with 5.
    add(1, 1, 0, 4'h3, 4'b0001, 1, 4'b1111, 16'hDC63, 32'h01010202);
    add(1, 1, 0, 4'h5, 4'b0001, 1, 4'b1111, 16'hDC65, 32'h01010203);
    // Drain everything with in_valid=0. The data registers keep their last words.
    add(1, 0, 0, 4'h0, 4'b1111, 1, 4'b0000, 16'hDC65, 32'h01010203);
    add(1, 0, 2, 4'hF, 4'b0000, 1, 4'b0000, 16'hDC65, 32'h01010203);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].ordy);
      #1;
      check($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_rdy));
      tick();
      check($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_ov));
      check($sformatf("v%0d out_data", i),  64'(bus.out_data),  64'(vecs[i].exp_od));
      check($sformatf("v%0d count", i),     64'(bus.count),     64'(vecs[i].exp_cnt));
    end

    // Back-to-back: 10 words into channel 0 while its consumer always takes.
    accepts = 0;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 1'b1, 2'd0, 4'(k), 4'b0001);
      #1;
      if (bus.in_ready) accepts++;
      tick();
    end
    check("b2b accepts",   64'(accepts),             64'd10);
    check("b2b valid0",    64'(bus.out_valid[0]),    64'd1);
    check("b2b d0",        64'(bus.out_data[3:0]),   64'hA);
    check("b2b count0",    64'(bus.count[7:0]),      64'd13);

    // Mid-run reset: load channels 1 and 2, then reset for one cycle.
    drive(1'b1, 1'b1, 2'd1, 4'h9, 4'b0000);
    tick();
    drive(1'b1, 1'b1, 2'd2, 4'h8, 4'b0000);
    tick();
    check("pre-reset valid", 64'(bus.out_valid), 64'b0111);
    drive(1'b0, 1'b0, 2'd0, 4'h0, 4'b1111);
    #1;
    check("reset in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("reset out_valid", 64'(bus.out_valid), 64'b0000);
    check("reset count",     64'(bus.count),     64'h0);
    check("reset out_data",  64'(bus.out_data),  64'h0);
    drive(1'b1, 1'b0, 2'd0, 4'h0, 4'b1111);
    tick();
    check("post-reset out_valid", 64'(bus.out_valid), 64'b0000);

    // Saturation with CNT_W=2: five accepts into channel 3 stop at 3.
    for (int k = 1; k <= 5; k++) begin
      bus2.in_valid  = 1'b1;
      bus2.in_sel    = 2'd3;
      bus2.in_data   = 4'(k);
      bus2.out_ready = 4'b1000;
      #1;
      check($sformatf("sat%0d in_ready", k), 64'(bus2.in_ready), 64'd1);
      tick();
      check($sformatf("sat%0d count3", k), 64'(bus2.count[7:6]), 64'((k > 3) ? 3 : k));
    end
    check("sat d3", 64'(bus2.out_data[15:12]), 64'h5);
    bus2.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, miscompares);
    $finish;
  end

endmodule
